adder_tree_scheduler: RTL

//   Shares one balanced adder tree (BalancedAdder, 2**EXPONENT lanes of DATA_WIDTH bits)

---
 rtl/adder_tree_sched_pkg.sv | 26 ++
 rtl/adder_tree_scheduler_balanced_adder.sv | 29 ++
 rtl/adder_tree_scheduler_rr_arbiter.sv | 50 +++++
 rtl/adder_tree_scheduler.sv | 134 +++++++++++++
 4 files changed

// File: rtl/adder_tree_sched_pkg.sv
// Shared types and sizing helpers for the adder tree scheduler.
package adder_tree_sched_pkg;

   // Scheduler states: waiting for work, summing the captured operands, presenting the result
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Default configuration
   localparam int DEF_EXPONENT   = 2;
   localparam int DEF_DATA_WIDTH = 4;
   localparam int DEF_NUM_REQ    = 3;

   // Width of a requester index (at least one bit)
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of one packed operand vector
   function automatic int lane_bits(input int e, input int w);
      return (1 << e) * w;
   endfunction

endpackage

// File: rtl/adder_tree_scheduler_balanced_adder.sv
// Balanced binary adder tree: 2**EXPONENT lanes reduced pairwise, sum wraps at DATA_WIDTH.
module BalancedAdder
   import adder_tree_sched_pkg::*;
#(
   parameter int EXPONENT   = DEF_EXPONENT,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [lane_bits(EXPONENT, DATA_WIDTH)-1:0] lanes_i,
   output logic [DATA_WIDTH-1:0]                      sum_o
);

   // Level 0 holds the raw lanes; each following level halves the node count
   for (genvar gi = 0; gi <= EXPONENT; gi++) begin : g_lvl
      localparam int CNT = 1 << (EXPONENT - gi);
      logic [CNT*DATA_WIDTH-1:0] vec;
      if (gi == 0) begin : g_leaf
         assign vec = lanes_i;
      end else begin : g_add
         for (genvar gj = 0; gj < CNT; gj++) begin : g_node
            assign vec[gj*DATA_WIDTH +: DATA_WIDTH] =
               g_lvl[gi-1].vec[(2*gj)*DATA_WIDTH +: DATA_WIDTH] +
               g_lvl[gi-1].vec[(2*gj+1)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sum_o = g_lvl[EXPONENT].vec;

endmodule

// File: rtl/adder_tree_scheduler_rr_arbiter.sv
// Round-robin arbiter: first valid request at or above the pointer wins, else wraps to the lowest.
module rr_arbiter
   import adder_tree_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_i,
   input  logic                             advance_i,
   output logic [NUM_REQ-1:0]               grant_o,
   output logic [id_width(NUM_REQ)-1:0]     grant_idx_o
);

   localparam int ID_W = id_width(NUM_REQ);

   logic [ID_W-1:0] ptr_q;
   logic            found;

   // Two passes: requesters from the pointer upward, then wrap-around from index 0
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i] && (ID_W'(i) >= ptr_q)) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = ID_W'(i);
            found       = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_i[i]) begin
            grant_o[i]  = 1'b1;
            grant_idx_o = ID_W'(i);
            found       = 1'b1;
         end
      end
   end

   // Pointer moves past the winner only when the grant is actually taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance_i) begin
         ptr_q <= (grant_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + ID_W'(1);
      end
   end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Shares one balanced adder tree among NUM_REQ requesters with round-robin arbitration.
module adder_tree_scheduler
   import adder_tree_sched_pkg::*;
#(
   parameter int EXPONENT   = DEF_EXPONENT,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [NUM_REQ-1:0]                                reqValid,
   input  logic [NUM_REQ*lane_bits(EXPONENT, DATA_WIDTH)-1:0] reqData,
   output logic [NUM_REQ-1:0]                                reqReady,
   output logic                                              rspValid,
   input  logic                                              rspReady,
   output logic [DATA_WIDTH-1:0]                             rspData,
   output logic [id_width(NUM_REQ)-1:0]                      rspId
);

   localparam int ID_W      = id_width(NUM_REQ);
   localparam int LANE_BITS = lane_bits(EXPONENT, DATA_WIDTH);

   state_t                 state_q, state_d;
   logic                   accept;
   logic                   any_valid;
   logic [NUM_REQ-1:0]     grant;
   logic [ID_W-1:0]        grant_idx;
   logic [LANE_BITS-1:0]   grant_data;
   logic [LANE_BITS-1:0]   operand_q;
   logic [ID_W-1:0]        id_q;
   logic [DATA_WIDTH-1:0]  rsp_data_q;
   logic [DATA_WIDTH-1:0]  tree_sum;

   assign any_valid = |reqValid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (reqValid),
      .advance_i   (accept),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   BalancedAdder #(
      .EXPONENT   (EXPONENT),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tree (
      .lanes_i (operand_q),
      .sum_o   (tree_sum)
   );

   // Select the granted requester's operand slice (grant is one-hot)
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_data = reqData[i*LANE_BITS +: LANE_BITS];
         end
      end
   end

   // Next state and accept decision; a new vector is only taken when no result is pending
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               accept  = 1'b1;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (rspReady) begin
               if (any_valid) begin
                  accept  = 1'b1;
                  state_d = COMPUTE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Reset also silences the handshake, since the arbiter is combinational from reqValid
      if (!rst_n) begin
         accept = 1'b0;
      end
   end

   assign reqReady = accept ? grant : '0;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the granted operands and owner; later changes on reqData do not matter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand_q <= '0;
         id_q      <= '0;
      end else if (accept) begin
         operand_q <= grant_data;
         id_q      <= grant_idx;
      end
   end

   // Register the tree output at the end of the compute cycle and keep it through HOLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_q <= '0;
      end else if (state_q == COMPUTE) begin
         rsp_data_q <= tree_sum;
      end
   end

   assign rspValid = (state_q == HOLD);
   assign rspData  = rsp_data_q;
   assign rspId    = id_q;

endmodule
